// File: rtl/fifo_pkg.sv
// Shared helpers for the synchronous FIFO: depth/pointer-width math and
// full/empty pointer comparisons on (ADDR_W+1)-bit wrap-bit pointers.
package fifo_pkg;

    localparam int PTR_EXTRA = 1;

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic int ptr_width(input int addr_w);
        return addr_w + PTR_EXTRA;
    endfunction

    // Full when only the wrap bit differs between the two pointers.
    function automatic logic ptr_full(input logic [31:0] w, input logic [31:0] r, input int addr_w);
        logic [31:0] wrap;
        logic [31:0] mask;
        wrap = 32'(1) << addr_w;
        mask = (wrap << 1) - 32'd1;
        return ((w ^ r) & mask) == wrap;
    endfunction

    function automatic logic ptr_empty(input logic [31:0] w, input logic [31:0] r, input int addr_w);
        logic [31:0] mask;
        mask = (32'(1) << (addr_w + 1)) - 32'd1;
        return ((w ^ r) & mask) == 32'd0;
    endfunction

endpackage

// File: rtl/fifo_ptr_cnt.sv
// Wrap-bit pointer counter: W-bit up-counter with synchronous active-high
// reset and an increment enable; rolls over naturally at 2**W.
module fifo_ptr_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else if (inc)
            value <= value + 1'b1;
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with count, almost flags and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word fall-through read behaviour.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 5,
    parameter int AF_THRESH = 28,
    parameter int AE_THRESH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    input  logic              err_clr
);

    localparam int PTR_W = ptr_width(ADDR_W);
    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam logic [PTR_W-1:0] AF_T = PTR_W'(AF_THRESH);
    localparam logic [PTR_W-1:0] AE_T = PTR_W'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wptr;
    logic [PTR_W-1:0]  rptr;
    logic              push_ok;
    logic              pop_ok;

    assign full         = ptr_full(32'(wptr), 32'(rptr), ADDR_W);
    assign empty        = ptr_empty(32'(wptr), 32'(rptr), ADDR_W);
    assign count        = wptr - rptr;
    assign almost_full  = count >= AF_T;
    assign almost_empty = count <= AE_T;

    // Accept decisions use the registered full/empty, so a push into a full
    // FIFO is rejected even when a pop frees a slot in the same cycle.
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;

    fifo_ptr_cnt #(.W(PTR_W)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (push_ok),
        .value (wptr)
    );

    fifo_ptr_cnt #(.W(PTR_W)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .inc   (pop_ok),
        .value (rptr)
    );

    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem[wptr[ADDR_W-1:0]] <= wr_data;
    end

    // A fresh error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !err_clr) || (wr_en && full);
            underflow <= (underflow && !err_clr) || (rd_en && empty);
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = empty ? '0 : mem[rptr[ADDR_W-1:0]];
    assign rd_valid = !empty;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok)
                rd_data <= mem[rptr[ADDR_W-1:0]];
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param (DATA_W=8, ADDR_W=5, AF=28, AE=4).
// Honours SYNC_FIFO_FWFT_EN to check the fall-through read variant.
module tb_sync_fifo_param;

    localparam int DEPTH = 32;
    localparam int AF    = 28;
    localparam int AE    = 4;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [5:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         m_count;
    logic       m_ovf;
    logic       m_unf;
    logic       m_valid;
    logic [7:0] m_rdata;

    sync_fifo_param #(
        .DATA_W    (8),
        .ADDR_W    (5),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare every output against the scoreboard-driven model.
    task automatic compareState();
        checkOutput("count", 32'(count), 32'(m_count));
        checkOutput("full", 32'(full), 32'(m_count == DEPTH));
        checkOutput("empty", 32'(empty), 32'(m_count == 0));
        checkOutput("almost_full", 32'(almost_full), 32'(m_count >= AF));
        checkOutput("almost_empty", 32'(almost_empty), 32'(m_count <= AE));
        checkOutput("overflow", 32'(overflow), 32'(m_ovf));
        checkOutput("underflow", 32'(underflow), 32'(m_unf));
`ifdef SYNC_FIFO_FWFT_EN
        checkOutput("rd_valid", 32'(rd_valid), 32'(m_count != 0));
        checkOutput("rd_data", 32'(rd_data), (m_count != 0) ? 32'(exp_q[0]) : 32'd0);
`else
        checkOutput("rd_valid", 32'(rd_valid), 32'(m_valid));
        checkOutput("rd_data", 32'(rd_data), 32'(m_rdata));
`endif
    endtask

    task automatic resetDut(input logic w, input logic r);
        rst     = 1'b1;
        wr_en   = w;
        rd_en   = r;
        wr_data = 8'h77;
        err_clr = 1'b0;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_rdata = 8'h00;
        compareState();
    endtask

    task automatic applyStimulus(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic was_full;
        logic was_empty;
        logic push_ok;
        logic pop_ok;
        wr_en     = w;
        wr_data   = d;
        rd_en     = r;
        err_clr   = c;
        was_full  = (m_count == DEPTH);
        was_empty = (m_count == 0);
        push_ok   = w && !was_full;
        pop_ok    = r && !was_empty;
        @(posedge clk);
        #1;
        m_ovf = (m_ovf && !c) || (w && was_full);
        m_unf = (m_unf && !c) || (r && was_empty);
        m_valid = pop_ok;
        if (pop_ok)
            m_rdata = exp_q.pop_front();
        if (push_ok)
            exp_q.push_back(d);
        m_count = exp_q.size();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        compareState();
    endtask

    initial begin
        logic [7:0] seq;
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
        wr_data = 8'h00;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        m_valid = 1'b0;
        m_rdata = 8'h00;

        resetDut(1'b0, 1'b0);
        resetDut(1'b0, 1'b0);
        checkOutput("reset_empty", 32'(empty), 32'd1);
        checkOutput("reset_almost_empty", 32'(almost_empty), 32'd1);

`ifdef SYNC_FIFO_FWFT_EN
        applyStimulus(1'b1, 8'h5C, 1'b0, 1'b0);
        checkOutput("fwft_data", 32'(rd_data), 32'h5C);
        checkOutput("fwft_valid", 32'(rd_valid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("fwft_drained", 32'(rd_valid), 32'd0);
`endif

        for (int i = 0; i < 32; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
        checkOutput("full_after_32", 32'(full), 32'd1);
        checkOutput("count_after_32", 32'(count), 32'd32);

        applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
        checkOutput("overflow_on_full", 32'(overflow), 32'd1);

        for (int i = 0; i < 32; i++)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("empty_after_drain", 32'(empty), 32'd1);

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("underflow_on_empty", 32'(underflow), 32'd1);
        checkOutput("no_valid_on_empty", 32'(rd_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("underflow_cleared", 32'(underflow), 32'd0);

        // Same-cycle new error beats err_clr.
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1);
        checkOutput("err_clr_loses", 32'(underflow), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

        seq = 8'h40;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, seq, 1'b0, 1'b0);
            seq++;
        end
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, seq, 1'b1, 1'b0);
            seq++;
        end
        checkOutput("count_steady_10", 32'(count), 32'd10);

        while (m_count < DEPTH) begin
            applyStimulus(1'b1, seq, 1'b0, 1'b0);
            seq++;
        end
        applyStimulus(1'b1, 8'hEE, 1'b1, 1'b0);
        checkOutput("full_pushpop_count", 32'(count), 32'd31);
        checkOutput("full_pushpop_ovf", 32'(overflow), 32'd1);

        while (m_count > 0)
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h3D, 1'b1, 1'b0);
        checkOutput("empty_pushpop_count", 32'(count), 32'd1);
        checkOutput("empty_pushpop_unf", 32'(underflow), 32'd1);

        for (int i = 0; i < 300; i++)
            applyStimulus(1'($urandom_range(0, 2) != 0), 8'($urandom),
                          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 7) == 0));

        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
        resetDut(1'b1, 1'b1);
        checkOutput("midop_reset_count", 32'(count), 32'd0);

        for (int i = 0; i < 200; i++)
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
